i2c_target: RTL and testbench

- Oversampled I2C target (slave) that sits directly downstream of the team's I2C master and consumes its scl/sda lines.
- Detects START/STOP and matches the 7-bit address.
- Acknowledges the address and write bytes, delivers received bytes to local logic, and serialises local data onto sda for reads.
- Drives an active-low acknowledge that wires directly to the master's ack_a input.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_sync_edge.sv | 35 +++
 rtl/i2c_target.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the oversampled I2C target: FSM states,
// bit-counter width and the bus acknowledge levels used by the master.
package i2c_pkg;

    localparam int CNT_W = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        WRITE,
        ACK_W,
        READ,
        MACK,
        IGNORE
    } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous bus line, followed by a
// history flop that yields one-cycle rise and fall pulses.
module i2c_sync_edge #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic h_q;

    // Idle I2C lines sit high, so resetting to 1 avoids a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= INIT;
            s2_q <= INIT;
            h_q  <= INIT;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            h_q  <= s2_q;
        end
    end

    assign lvl_o  = s2_q;
    assign rise_o = s2_q & ~h_q;
    assign fall_o = ~s2_q & h_q;

endmodule

// File: rtl/i2c_target.sv
// Oversampled I2C target: START/STOP detection, address match, write
// byte delivery with ACK, and serialised read data from local logic.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int             N        = 7,
    parameter logic [N-1:0]   DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       ack_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .clk    (clk),
        .rst    (rst),
        .d_i    (scl_in),
        .lvl_o  (scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sda_in),
        .lvl_o  (sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic start_det;
    logic stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       first_q, first_d;
    logic       oe_q, oe_d;
    logic       ackn_q, ackn_d;
    logic       busy_q, busy_d;
    logic [7:0] rxd_q, rxd_d;
    logic       rxv_q, rxv_d;
    logic       rxf_q, rxf_d;
    logic       load;
    logic [7:0] shifted;

    assign shifted = {sr_q[6:0], sda_lvl};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            rw_q    <= 1'b0;
            mack_q  <= 1'b0;
            first_q <= 1'b0;
            oe_q    <= 1'b0;
            ackn_q  <= NACK;
            busy_q  <= 1'b0;
            rxd_q   <= '0;
            rxv_q   <= 1'b0;
            rxf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            rw_q    <= rw_d;
            mack_q  <= mack_d;
            first_q <= first_d;
            oe_q    <= oe_d;
            ackn_q  <= ackn_d;
            busy_q  <= busy_d;
            rxd_q   <= rxd_d;
            rxv_q   <= rxv_d;
            rxf_q   <= rxf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        rw_d    = rw_q;
        mack_d  = mack_q;
        first_d = first_q;
        oe_d    = oe_q;
        ackn_d  = ackn_q;
        busy_d  = busy_q;
        rxd_d   = rxd_q;
        rxv_d   = 1'b0;
        rxf_d   = 1'b0;
        load    = 1'b0;

        if (start_det) begin
            state_d = ADDR;
            cnt_d   = cnt_t'(N);
            sr_d    = '0;
            mack_d  = 1'b0;
            oe_d    = 1'b0;
            ackn_d  = NACK;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
            mack_d  = 1'b0;
            oe_d    = 1'b0;
            ackn_d  = NACK;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        sr_d  = shifted;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            rw_d    = shifted[0];
                            state_d = (shifted[N:1] == DEV_ADDR) ? ACK_A : IGNORE;
                        end
                    end
                end
                ACK_A, ACK_W: begin
                    if (scl_fall) begin
                        if (ackn_q == NACK) begin
                            oe_d   = 1'b1;
                            ackn_d = ACK;
                            busy_d = 1'b1;
                        end else begin
                            ackn_d = NACK;
                            cnt_d  = cnt_t'(7);
                            if (state_q == ACK_A && rw_q) begin
                                load    = 1'b1;
                                sr_d    = tx_data;
                                oe_d    = ~tx_data[7];
                                state_d = READ;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = WRITE;
                                if (state_q == ACK_A) first_d = 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        sr_d  = shifted;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            rxd_d   = shifted;
                            rxv_d   = 1'b1;
                            rxf_d   = first_q;
                            first_d = 1'b0;
                            state_d = ACK_W;
                        end
                    end
                end
                READ: begin
                    // sr_q[7] is the bit on the wire; shift to expose the next one.
                    if (scl_fall) begin
                        if (cnt_q != '0) begin
                            sr_d  = {sr_q[6:0], 1'b0};
                            oe_d  = ~sr_q[6];
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            mack_d  = 1'b0;
                            state_d = MACK;
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == ACK) mack_d = 1'b1;
                        else state_d = IGNORE;
                    end else if (scl_fall && mack_q) begin
                        load    = 1'b1;
                        sr_d    = tx_data;
                        oe_d    = ~tx_data[7];
                        cnt_d   = cnt_t'(7);
                        mack_d  = 1'b0;
                        state_d = READ;
                    end
                end
                IGNORE: oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda_oe   = oe_q;
    assign ack_n    = ackn_q;
    assign rx_data  = rxd_q;
    assign rx_valid = rxv_q;
    assign rx_first = rxf_q;
    assign tx_load  = load;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged master on a wired-AND sda line,
// directed scenarios plus randomised transactions against a byte model.
module tb_i2c_target;

    localparam logic [6:0] DEV = 7'h50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe, ack_n, rx_valid, rx_first, tx_load, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int errors = 0;
    int checks = 0;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_target #(.N(7), .DEV_ADDR(DEV)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .ack_n    (ack_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic       rxf_q[$];
    int         tx_loads  = 0;
    int         oe_cycles = 0;
    int         ackn_low  = 0;
    int         since     = 99;
    logic       scl_prev  = 1'b1;
    logic       oe_prev   = 1'b0;

    // Event log plus the sda_oe-to-scl-fall timing rule.
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rxf_q.push_back(rx_first);
        end
        if (tx_load) tx_loads++;
        if (sda_oe) oe_cycles++;
        if (!ack_n) ackn_low++;
        if (scl_prev && !m_scl) since = 1;
        else if (since < 99) since++;
        scl_prev = m_scl;
        if (rst && sda_oe !== oe_prev) begin
            checks++;
            if (since < 1 || since > 3) begin
                errors++;
                $display("FAIL oe_timing: sda_oe->%b at %0d clk after scl fall, want 1..3",
                         sda_oe, since);
            end
        end
        oe_prev = sda_oe;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic hc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        hc(2);
        m_sda = 1'b1;
        hc(2);
        m_scl = 1'b1;
        hc(4);
        m_sda = 1'b0;
        hc(4);
        m_scl = 1'b0;
    endtask

    task automatic m_stop();
        hc(2);
        m_sda = 1'b0;
        hc(2);
        m_scl = 1'b1;
        hc(4);
        m_sda = 1'b1;
        hc(6);
    endtask

    task automatic m_bit(input logic b, input logic g,
                         output logic s, output logic an, output logic oe);
        if (g) begin
            hc(1); m_sda = ~b;
            hc(1); m_sda = b;
            hc(1); m_sda = ~b;
            hc(1);
        end else begin
            hc(4);
        end
        m_sda = b;
        hc(4);
        m_scl = 1'b1;
        hc(4);
        s  = sda_bus;
        an = ack_n;
        oe = sda_oe;
        hc(4);
        m_scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic g,
                           output logic ack, output logic an, output logic oe);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(d[i], g, s, an, oe);
        m_bit(1'b1, 1'b0, s, an, oe);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic mack, input logic [7:0] nxt,
                           output logic [7:0] d);
        logic s, an, oe;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, 1'b0, s, an, oe);
            d[i] = s;
        end
        tx_data = nxt;
        m_bit(mack, 1'b0, s, an, oe);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hc(3);
        checks++;
        if (sda_oe !== 1'b0 || ack_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: oe=%b ack_n=%b busy=%b want 0 1 0", sda_oe, ack_n, busy);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_first !== 1'b0 || tx_load !== 1'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx: rxv=%b rxf=%b txl=%b rxd=%h want 0 0 0 00",
                     rx_valid, rx_first, tx_load, rx_data);
        end
        rst = 1'b1;
        hc(4);
    endtask

    task automatic test_write();
        logic ack, an, oe;
        logic [7:0] bytes [3];
        bytes[0] = 8'hA0; bytes[1] = 8'h3C; bytes[2] = 8'h81;
        rx_q.delete(); rxf_q.delete();
        m_start();
        for (int k = 0; k < 3; k++) begin
            wr_byte(bytes[k], 1'b0, ack, an, oe);
            checks++;
            if (ack !== 1'b1 || an !== 1'b0 || oe !== 1'b1) begin
                errors++;
                $display("FAIL write_ack%0d: ack=%b ack_n=%b oe=%b want 1 0 1", k, ack, an, oe);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy: got %b want 1", busy);
        end
        m_stop();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL write_busy_stop: got %b want 0", busy);
        end
        checks++;
        if (rx_q.size() != 2) begin
            errors++;
            $display("FAIL write_count: got %0d want 2", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== 8'h3C || rxf_q[0] !== 1'b1 || rx_q[1] !== 8'h81 || rxf_q[1] !== 1'b0) begin
                errors++;
                $display("FAIL write_data: got %h/%b %h/%b want 3c/1 81/0",
                         rx_q[0], rxf_q[0], rx_q[1], rxf_q[1]);
            end
        end
    endtask

    task automatic test_mismatch();
        logic ack, an, oe;
        int oe0, an0, tl0, rx0;
        oe0 = oe_cycles; an0 = ackn_low; tl0 = tx_loads; rx0 = rx_q.size();
        m_start();
        wr_byte(8'hA2, 1'b0, ack, an, oe);
        checks++;
        if (ack !== 1'b0 || an !== 1'b1) begin
            errors++;
            $display("FAIL mis_addr_ack: ack=%b ack_n=%b want 0 1", ack, an);
        end
        wr_byte(8'h55, 1'b0, ack, an, oe);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mis_data: ack=%b busy=%b want 0 0", ack, busy);
        end
        m_stop();
        checks++;
        if (oe_cycles != oe0 || ackn_low != an0) begin
            errors++;
            $display("FAIL mis_drive: oe_cycles +%0d ackn_low +%0d want +0 +0",
                     oe_cycles - oe0, ackn_low - an0);
        end
        checks++;
        if (tx_loads != tl0 || rx_q.size() != rx0) begin
            errors++;
            $display("FAIL mis_events: tx_load +%0d rx_valid +%0d want +0 +0",
                     tx_loads - tl0, rx_q.size() - rx0);
        end
    endtask

    task automatic test_read();
        logic ack, an, oe;
        logic [7:0] d;
        int tl0;
        tl0 = tx_loads;
        tx_data = 8'hA5;
        m_start();
        wr_byte(8'hA1, 1'b0, ack, an, oe);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL read_addr_ack: got %b want 1", ack);
        end
        rd_byte(1'b0, 8'h0F, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL read_b0: got %h want a5", d);
        end
        rd_byte(1'b1, 8'h00, d);
        checks++;
        if (d !== 8'h0F) begin
            errors++;
            $display("FAIL read_b1: got %h want 0f", d);
        end
        hc(4);
        checks++;
        if (sda_oe !== 1'b0 || tx_loads - tl0 != 2) begin
            errors++;
            $display("FAIL read_end: oe=%b tx_loads=%0d want 0 2", sda_oe, tx_loads - tl0);
        end
        m_stop();
    endtask

    task automatic test_rep_start();
        logic ack, an, oe, s;
        logic [7:0] d, t;
        int rx0;
        rx0 = rx_q.size();
        t = 8'($urandom);
        tx_data = t;
        m_start();
        wr_byte(8'hA0, 1'b0, ack, an, oe);
        for (int i = 0; i < 4; i++) m_bit(1'b1, 1'b0, s, an, oe);
        m_start();
        wr_byte(8'hA1, 1'b0, ack, an, oe);
        checks++;
        if (ack !== 1'b1 || an !== 1'b0) begin
            errors++;
            $display("FAIL rs_ack: ack=%b ack_n=%b want 1 0", ack, an);
        end
        rd_byte(1'b1, 8'h00, d);
        checks++;
        if (d !== t) begin
            errors++;
            $display("FAIL rs_read: got %h want %h", d, t);
        end
        m_stop();
        checks++;
        if (rx_q.size() != rx0) begin
            errors++;
            $display("FAIL rs_partial: rx_valid +%0d want +0", rx_q.size() - rx0);
        end
    endtask

    task automatic test_reset_mid();
        logic ack, an, oe, s;
        logic [7:0] d;
        rx_q.delete(); rxf_q.delete();
        m_start();
        wr_byte(8'hA0, 1'b0, ack, an, oe);
        for (int i = 0; i < 4; i++) m_bit(1'b0, 1'b0, s, an, oe);
        hc(4);
        m_sda = 1'b1;
        hc(2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rm_busy_pre: got %b want 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sda_oe !== 1'b0 || ack_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: oe=%b ack_n=%b busy=%b want 0 1 0", sda_oe, ack_n, busy);
        end
        m_scl = 1'b1;
        m_sda = 1'b1;
        hc(4);
        rst = 1'b1;
        hc(4);
        d = 8'($urandom);
        m_start();
        wr_byte(8'hA0, 1'b0, ack, an, oe);
        wr_byte(d, 1'b0, ack, an, oe);
        m_stop();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== d || rxf_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL rm_after: n=%0d byte=%h want 1 %h", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'h00, d);
        end
    endtask

    task automatic test_glitch();
        logic ack, an, oe;
        logic [7:0] d;
        rx_q.delete(); rxf_q.delete();
        d = 8'($urandom);
        m_start();
        wr_byte(8'hA0, 1'b1, ack, an, oe);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL gl_addr: ack=%b want 1", ack);
        end
        wr_byte(d, 1'b1, ack, an, oe);
        checks++;
        if (ack !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gl_data: ack=%b busy=%b want 1 1", ack, busy);
        end
        m_stop();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== d) begin
            errors++;
            $display("FAIL gl_rx: n=%0d byte=%h want 1 %h", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'h00, d);
        end
    endtask

    task automatic test_random();
        logic ack, an, oe, match, is_rd;
        logic [6:0] addr;
        logic [7:0] d;
        logic [7:0] tx [4];
        logic [7:0] exp_q[$];
        int nb, tl0;
        for (int it = 0; it < 16; it++) begin
            is_rd = 1'($urandom_range(0, 1));
            match = ($urandom_range(0, 3) != 0);
            addr = DEV;
            while (!match && addr == DEV) addr = 7'($urandom);
            nb = $urandom_range(1, 3);
            rx_q.delete(); rxf_q.delete(); exp_q.delete();
            for (int k = 0; k < 4; k++) tx[k] = 8'($urandom);
            tx_data = tx[0];
            tl0 = tx_loads;
            m_start();
            wr_byte({addr, is_rd}, 1'b0, ack, an, oe);
            checks++;
            if (ack !== match) begin
                errors++;
                $display("FAIL rnd%0d_addr: ack=%b want %b (addr %h)", it, ack, match, addr);
            end
            for (int k = 0; k < nb; k++) begin
                if (is_rd) begin
                    rd_byte(k == nb - 1, tx[k+1], d);
                    checks++;
                    if (d !== (match ? tx[k] : 8'hFF)) begin
                        errors++;
                        $display("FAIL rnd%0d_rd%0d: got %h want %h", it, k, d,
                                 match ? tx[k] : 8'hFF);
                    end
                end else begin
                    d = 8'($urandom);
                    wr_byte(d, 1'b0, ack, an, oe);
                    if (match) exp_q.push_back(d);
                    checks++;
                    if (ack !== match) begin
                        errors++;
                        $display("FAIL rnd%0d_wack%0d: got %b want %b", it, k, ack, match);
                    end
                end
            end
            m_stop();
            if (is_rd) begin
                checks++;
                if (tx_loads - tl0 != (match ? nb : 0)) begin
                    errors++;
                    $display("FAIL rnd%0d_txload: got %0d want %0d", it, tx_loads - tl0,
                             match ? nb : 0);
                end
            end else begin
                checks++;
                if (rx_q.size() != exp_q.size()) begin
                    errors++;
                    $display("FAIL rnd%0d_rxn: got %0d want %0d", it, rx_q.size(), exp_q.size());
                end else begin
                    for (int k = 0; k < exp_q.size(); k++) begin
                        checks++;
                        if (rx_q[k] !== exp_q[k] || rxf_q[k] !== (k == 0)) begin
                            errors++;
                            $display("FAIL rnd%0d_rx%0d: got %h/%b want %h/%b", it, k,
                                     rx_q[k], rxf_q[k], exp_q[k], k == 0);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_rep_start();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
